time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter.sv | 100 ++++++++++
 tb/tb_time_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
// time_counter : HH:MM:SS time-of-day counter (24h, or 12h with PM flag)
//                with minute/hour set-advance.
// Revision     : 1.0
// ============================================================================
module time_counter #(
  parameter int TWELVE_HOUR = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_1hz_stb,
  input  logic       i_set_stb,
  input  logic       i_min_set,
  input  logic       i_hr_set,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic       o_pm,
  output logic       o_rollover
);

  localparam logic       c_twelve   = (TWELVE_HOUR != 0);
  localparam logic [4:0] c_hour_min = c_twelve ? 5'd1  : 5'd0;
  localparam logic [4:0] c_hour_max = c_twelve ? 5'd12 : 5'd23;
  localparam logic [4:0] c_hour_rst = c_twelve ? 5'd12 : 5'd0;
  localparam logic [5:0] c_sixty_m1 = 6'd59;

  logic [4:0] r_hours, w_hours_nxt, w_hours_inc;
  logic [5:0] r_minutes, w_minutes_nxt, w_minutes_inc;
  logic [5:0] r_seconds, w_seconds_nxt, w_seconds_inc;
  logic       r_pm, w_pm_nxt;
  logic       r_rollover, w_rollover_nxt;
  logic       w_set_mode, w_set_evt, w_count_evt;
  logic       w_sec_wrap, w_min_wrap, w_pm_toggle;

  // Set levels mask the 1 Hz strobe entirely, so set wins any collision.
  assign w_set_mode  = i_min_set | i_hr_set;
  assign w_set_evt   = i_set_stb & w_set_mode;
  assign w_count_evt = i_1hz_stb & i_en & ~w_set_mode;

  assign w_sec_wrap    = (r_seconds >= c_sixty_m1);
  assign w_min_wrap    = (r_minutes >= c_sixty_m1);
  assign w_seconds_inc = w_sec_wrap ? 6'd0 : r_seconds + 6'd1;
  assign w_minutes_inc = w_min_wrap ? 6'd0 : r_minutes + 6'd1;
  assign w_hours_inc   = (r_hours >= c_hour_max) ? c_hour_min : r_hours + 5'd1;
  assign w_pm_toggle   = c_twelve && (r_hours == 5'd11);

  always_comb begin
    w_hours_nxt    = r_hours;
    w_minutes_nxt  = r_minutes;
    w_seconds_nxt  = r_seconds;
    w_pm_nxt       = r_pm;
    w_rollover_nxt = 1'b0;
    if (w_set_evt) begin
      w_seconds_nxt = 6'd0;
      if (i_min_set) w_minutes_nxt = w_minutes_inc;
      if (i_hr_set) begin
        w_hours_nxt = w_hours_inc;
        if (w_pm_toggle) w_pm_nxt = ~r_pm;
      end
    end else if (w_count_evt) begin
      w_seconds_nxt = w_seconds_inc;
      if (w_sec_wrap) begin
        w_minutes_nxt = w_minutes_inc;
        if (w_min_wrap) begin
          w_hours_nxt = w_hours_inc;
          if (w_pm_toggle) w_pm_nxt = ~r_pm;
          // 12h mode wraps the day when PM is about to fall back to AM.
          w_rollover_nxt = c_twelve ? (w_pm_toggle & r_pm) : (r_hours >= c_hour_max);
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hours    <= c_hour_rst;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_pm       <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_hours    <= w_hours_nxt;
      r_minutes  <= w_minutes_nxt;
      r_seconds  <= w_seconds_nxt;
      r_pm       <= w_pm_nxt;
      r_rollover <= w_rollover_nxt;
    end
  end

  assign o_hours    = r_hours;
  assign o_minutes  = r_minutes;
  assign o_seconds  = r_seconds;
  assign o_pm       = r_pm;
  assign o_rollover = r_rollover;

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
// tb_time_counter : scoreboard bench for time_counter in 24h and 12h modes.
// Revision        : 1.0
// ============================================================================
module tb_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, hz = 1'b0, st = 1'b0, ms = 1'b0, hs = 1'b0;

  logic [4:0] h24, h12;
  logic [5:0] m24, m12, s24, s12;
  logic       pm24, pm12, ro24, ro12;

  always #5 clk = ~clk;

  time_counter #(.TWELVE_HOUR(0)) dut24 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(st),
    .i_min_set(ms), .i_hr_set(hs), .o_hours(h24), .o_minutes(m24),
    .o_seconds(s24), .o_pm(pm24), .o_rollover(ro24)
  );

  time_counter #(.TWELVE_HOUR(1)) dut12 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(st),
    .i_min_set(ms), .i_hr_set(hs), .o_hours(h12), .o_minutes(m12),
    .o_seconds(s12), .o_pm(pm12), .o_rollover(ro12)
  );

  typedef struct {
    string      nm;
    bit         sel12;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
    logic       ro;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: outputs are sampled 1 ns after each clock edge or reset assertion.
  initial begin
    exp_t e;
    logic [4:0] ah;
    logic [5:0] am, as;
    logic       apm, aro;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        ah  = e.sel12 ? h12  : h24;
        am  = e.sel12 ? m12  : m24;
        as  = e.sel12 ? s12  : s24;
        apm = e.sel12 ? pm12 : pm24;
        aro = e.sel12 ? ro12 : ro24;
        n_checks++;
        if (ah !== e.h || am !== e.m || as !== e.s || apm !== e.pm || aro !== e.ro) begin
          n_fail++;
          $display("FAIL %s: got %0d:%0d:%0d pm=%b ro=%b, expected %0d:%0d:%0d pm=%b ro=%b",
                   e.nm, ah, am, as, apm, aro, e.h, e.m, e.s, e.pm, e.ro);
        end
      end
    end
  end

  task automatic push(input string nm, input bit sel, input int h, input int m,
                      input int s, input bit pm, input bit ro);
    exp_t e;
    e.nm = nm; e.sel12 = sel; e.h = 5'(h); e.m = 6'(m); e.s = 6'(s);
    e.pm = pm; e.ro = ro;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit en_v, input bit hz_v, input bit st_v,
                      input bit ms_v, input bit hs_v);
    @(negedge clk);
    en = en_v; hz = hz_v; st = st_v; ms = ms_v; hs = hs_v;
    @(posedge clk);
    #2;
    hz = 1'b0; st = 1'b0;
  endtask

  task automatic step_chk(input bit en_v, input bit hz_v, input bit st_v,
                          input bit ms_v, input bit hs_v, input string nm,
                          input bit sel, input int h, input int m, input int s,
                          input bit pm, input bit ro);
    @(negedge clk);
    en = en_v; hz = hz_v; st = st_v; ms = ms_v; hs = hs_v;
    push(nm, sel, h, m, s, pm, ro);
    @(posedge clk);
    #2;
    hz = 1'b0; st = 1'b0;
  endtask

  // Assert reset mid-cycle and expect reset values before the next edge.
  task automatic reset_chk(input string nm, input bit sel, input int h);
    @(negedge clk);
    push(nm, sel, h, 0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 24-hour mode
    step_chk(1, 1, 0, 0, 0, "count1", 0, 0, 0, 1, 0, 0);
    step_chk(1, 1, 0, 0, 0, "count2", 0, 0, 0, 2, 0, 0);
    reset_chk("rst24", 0, 0);
    step_chk(1, 1, 0, 0, 0, "post_rst", 0, 0, 0, 1, 0, 0);
    reset_chk("rst12", 1, 12);

    repeat (22) step(1, 0, 1, 1, 1);
    step_chk(1, 0, 1, 1, 1, "set_both", 0, 23, 23, 0, 0, 0);
    repeat (35) step(1, 0, 1, 1, 0);
    step_chk(1, 0, 1, 1, 0, "set_min59", 0, 23, 59, 0, 0, 0);
    repeat (57) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "sec58", 0, 23, 59, 58, 0, 0);
    step_chk(1, 1, 0, 0, 0, "sec59", 0, 23, 59, 59, 0, 0);
    step_chk(1, 1, 0, 0, 0, "day_wrap", 0, 0, 0, 0, 0, 1);
    step_chk(1, 0, 0, 0, 0, "ro_end", 0, 0, 0, 0, 0, 0);

    repeat (6) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "hr7", 0, 7, 0, 0, 0, 0);
    repeat (57) step(1, 0, 1, 1, 0);
    step_chk(1, 0, 1, 1, 0, "min58", 0, 7, 58, 0, 0, 0);
    repeat (29) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "sec30", 0, 7, 58, 30, 0, 0);
    step_chk(1, 0, 1, 1, 0, "mset59", 0, 7, 59, 0, 0, 0);
    step_chk(1, 0, 1, 1, 0, "mset_wrap", 0, 7, 0, 0, 0, 0);
    step_chk(1, 0, 1, 1, 0, "mset1", 0, 7, 1, 0, 0, 0);

    repeat (16) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "hset_wrap", 0, 0, 1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "hset5", 0, 5, 1, 0, 0, 0);
    repeat (9) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "sec10", 0, 5, 1, 10, 0, 0);
    step_chk(1, 1, 1, 0, 1, "collide", 0, 6, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 1, "hz_masked", 0, 6, 1, 0, 0, 0);

    repeat (4) step(0, 1, 0, 0, 0);
    step_chk(0, 1, 0, 0, 0, "en_freeze", 0, 6, 1, 0, 0, 0);
    step_chk(0, 0, 1, 0, 1, "en_set", 0, 7, 1, 0, 0, 0);
    repeat (58) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "sec59b", 0, 7, 1, 59, 0, 0);
    step_chk(1, 1, 0, 0, 0, "min_carry", 0, 7, 2, 0, 0, 0);

    // 12-hour mode
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    step_chk(1, 0, 1, 0, 1, "h12_set_wrap", 1, 1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "h12_11am", 1, 11, 0, 0, 0, 0);
    repeat (58) step(1, 0, 1, 1, 0);
    step_chk(1, 0, 1, 1, 0, "h12_m59", 1, 11, 59, 0, 0, 0);
    repeat (58) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "h12_s59", 1, 11, 59, 59, 0, 0);
    step_chk(1, 1, 0, 0, 0, "h12_noon", 1, 12, 0, 0, 1, 0);
    repeat (59) step(1, 0, 1, 1, 0);
    repeat (58) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "h12_1259", 1, 12, 59, 59, 1, 0);
    step_chk(1, 1, 0, 0, 0, "h12_one", 1, 1, 0, 0, 1, 0);
    repeat (9) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "h12_11pm", 1, 11, 0, 0, 1, 0);
    repeat (59) step(1, 0, 1, 1, 0);
    repeat (58) step(1, 1, 0, 0, 0);
    step_chk(1, 1, 0, 0, 0, "h12_pre_mid", 1, 11, 59, 59, 1, 0);
    step_chk(1, 1, 0, 0, 0, "h12_midnight", 1, 12, 0, 0, 0, 1);
    step_chk(1, 0, 0, 0, 0, "h12_ro_end", 1, 12, 0, 0, 0, 0);
    repeat (11) step(1, 0, 1, 0, 1);
    step_chk(1, 0, 1, 0, 1, "h12_set_pm", 1, 12, 0, 0, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
